// File: rtl/morse_key_capture_if.sv
// Signal bundle between a Morse key source and morse_key_capture.
// The master drives the raw key; the slave returns the captured letter.
interface morse_key_capture_if;
    logic       key_in;
    logic       key_level;
    logic [1:0] morse_one;
    logic [1:0] morse_two;
    logic [1:0] morse_three;
    logic [1:0] morse_four;
    logic [1:0] morse_five;
    logic [2:0] symbol_count;
    logic       letter_done;
    logic       overflow;

    modport master (
        output key_in,
        input  key_level, morse_one, morse_two, morse_three, morse_four,
               morse_five, symbol_count, letter_done, overflow
    );

    modport slave (
        input  key_in,
        output key_level, morse_one, morse_two, morse_three, morse_four,
               morse_five, symbol_count, letter_done, overflow
    );
endinterface

// File: rtl/morse_key_capture.sv
// Key front end for morse_decoder: synchronise, debounce, classify presses as
// dot/dash into five 2-bit slots and strobe letter_done after an idle gap.
module morse_key_capture #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned DASH_CYCLES       = 25000000,
    parameter int unsigned LETTER_GAP_CYCLES = 60000000,
    parameter int unsigned CNT_W             = 27
) (
    input  logic               clk,
    input  logic               reset_n,
    morse_key_capture_if.slave kif
);
    typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_MAX = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP_CYCLES - 1);

    logic             key_meta, key_sync;
    logic             key_level, key_level_d;
    logic [CNT_W-1:0] deb_cnt;
    logic             rise, fall;

    state_t           state, state_next;
    logic [CNT_W-1:0] press_cnt, press_inc, gap_cnt;
    logic [1:0]       symbol;
    logic [1:0]       slots [5];
    logic [2:0]       symbol_count;
    logic             ovf_flag;
    logic             done_set, ovf_set;
    logic             letter_done, overflow;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would turn the two-flop synchroniser into one flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= kif.key_in;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt     <= '0;
            key_level   <= 1'b0;
            key_level_d <= 1'b0;
        end else begin
            key_level_d <= key_level;
            if (key_sync == key_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                key_level <= ~key_level;
            end else begin
                deb_cnt <= deb_cnt + CNT_ONE;
            end
        end
    end

    assign rise = key_level & ~key_level_d;
    assign fall = ~key_level & key_level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_level) state_next = PRESS;
            PRESS:   if (fall) state_next = GAP;
            GAP: begin
                if (rise)                    state_next = PRESS;
                else if (gap_cnt == GAP_LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done_set = 1'b0;
        ovf_set  = 1'b0;
        if (state == GAP && state_next == DONE) begin
            done_set = ~ovf_flag;
            ovf_set  = ovf_flag;
        end
    end

    // The press decision counts the release cycle too, so press_inc equals the
    // number of cycles key_level was high.
    assign press_inc = (press_cnt == DASH_MAX) ? press_cnt : press_cnt + CNT_ONE;
    assign symbol    = (press_inc == DASH_MAX) ? 2'b10 : 2'b01;

    // NOTE: the five slots are a handful of flops, not a RAM, so they are reset
    // like any other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_cnt    <= '0;
            gap_cnt      <= '0;
            symbol_count <= 3'd0;
            ovf_flag     <= 1'b0;
            letter_done  <= 1'b0;
            overflow     <= 1'b0;
            for (int i = 0; i < 5; i++) slots[i] <= 2'b00;
        end else begin
            letter_done <= done_set;
            overflow    <= ovf_set;
            case (state)
                IDLE: begin
                    press_cnt <= '0;
                    gap_cnt   <= '0;
                end
                PRESS: begin
                    press_cnt <= press_inc;
                    if (fall) begin
                        gap_cnt <= '0;
                        if (symbol_count < 3'd5) begin
                            slots[symbol_count] <= symbol;
                            symbol_count        <= symbol_count + 3'd1;
                        end else begin
                            ovf_flag <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (rise) begin
                        gap_cnt   <= '0;
                        press_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    symbol_count <= 3'd0;
                    ovf_flag     <= 1'b0;
                    for (int i = 0; i < 5; i++) slots[i] <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign kif.key_level    = key_level;
    assign kif.morse_one    = slots[0];
    assign kif.morse_two    = slots[1];
    assign kif.morse_three  = slots[2];
    assign kif.morse_four   = slots[3];
    assign kif.morse_five   = slots[4];
    assign kif.symbol_count = symbol_count;
    assign kif.letter_done  = letter_done;
    assign kif.overflow     = overflow;
endmodule

// File: tb/tb_morse_key_capture.sv
// Directed bench for morse_key_capture with short timing parameters
// (debounce 4, dash 10, letter gap 20 cycles).
module tb_morse_key_capture;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   done_pulses = 0;
    int   ovf_pulses  = 0;

    morse_key_capture_if kif ();

    morse_key_capture #(
        .DEBOUNCE_CYCLES  (4),
        .DASH_CYCLES      (10),
        .LETTER_GAP_CYCLES(20),
        .CNT_W            (27)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kif    (kif)
    );

    always #5 clk = ~clk;

    logic [9:0]  slots_w;
    logic [15:0] outs_w;
    assign slots_w = {kif.morse_one, kif.morse_two, kif.morse_three, kif.morse_four, kif.morse_five};
    assign outs_w  = {kif.key_level, slots_w, kif.symbol_count, kif.letter_done, kif.overflow};

    always @(negedge clk) begin
        if (kif.letter_done) done_pulses++;
        if (kif.overflow)    ovf_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int n);
        kif.key_in = 1'b1;
        repeat (n) @(negedge clk);
        kif.key_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge of the first strobe cycle, or after limit cycles.
    task automatic wait_event(input int limit, output logic got_done, output logic got_ovf);
        got_done = 1'b0;
        got_ovf  = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (kif.letter_done || kif.overflow) begin
                got_done = kif.letter_done;
                got_ovf  = kif.overflow;
                break;
            end
        end
    endtask

    initial begin
        logic       got_done, got_ovf;
        logic [15:0] acc;
        int          base;

        kif.key_in = 1'b0;
        reset_n    = 1'b0;
        idle(3);
        check("reset_outputs", 32'(outs_w), 32'h0);
        reset_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            acc |= outs_w;
        end
        check("post_reset_quiet", 32'(acc), 32'h0);

        // Letter L: dot dash dot dot
        base = done_pulses;
        press(5);  idle(8);
        press(15); idle(8);
        press(5);  idle(8);
        press(5);
        wait_event(100, got_done, got_ovf);
        check("L_done", 32'(got_done), 32'h1);
        check("L_no_ovf", 32'(got_ovf), 32'h0);
        check("L_slots", 32'(slots_w), 32'(10'b01_10_01_01_00));
        check("L_count", 32'(kif.symbol_count), 32'h4);
        @(negedge clk);
        check("L_slots_clear", 32'(slots_w), 32'h0);
        check("L_count_clear", 32'(kif.symbol_count), 32'h0);
        check("L_done_one_cycle", 32'(kif.letter_done), 32'h0);
        idle(10);
        check("L_single_pulse", 32'(done_pulses - base), 32'h1);

        // Dot/dash threshold at 9 and 10 cycles of key_level
        press(9);
        wait_event(100, got_done, got_ovf);
        check("T9_done", 32'(got_done), 32'h1);
        check("T9_dot", 32'(kif.morse_one), 32'h1);
        check("T9_count", 32'(kif.symbol_count), 32'h1);
        idle(3);
        press(10);
        wait_event(100, got_done, got_ovf);
        check("T10_done", 32'(got_done), 32'h1);
        check("T10_dash", 32'(kif.morse_one), 32'h2);
        check("T10_count", 32'(kif.symbol_count), 32'h1);
        idle(3);

        // Bounce: 3-cycle pulses never make it through the debouncer
        base = done_pulses + ovf_pulses;
        acc  = '0;
        for (int i = 0; i < 8; i++) begin
            kif.key_in = 1'b1;
            for (int j = 0; j < 3; j++) begin @(negedge clk); acc[0] |= kif.key_level; end
            kif.key_in = 1'b0;
            for (int j = 0; j < 3; j++) begin @(negedge clk); acc[0] |= kif.key_level; end
        end
        for (int j = 0; j < 40; j++) begin @(negedge clk); acc[0] |= kif.key_level; end
        check("bounce_level", 32'(acc[0]), 32'h0);
        check("bounce_strobes", 32'(done_pulses + ovf_pulses - base), 32'h0);
        check("bounce_count", 32'(kif.symbol_count), 32'h0);

        // Overflow: six dots
        base = done_pulses;
        for (int i = 0; i < 5; i++) begin
            press(5);
            idle(8);
        end
        press(5);
        wait_event(100, got_done, got_ovf);
        check("ovf_seen", 32'(got_ovf), 32'h1);
        check("ovf_no_done", 32'(got_done), 32'h0);
        check("ovf_slots_kept", 32'(slots_w), 32'(10'b01_01_01_01_01));
        check("ovf_count", 32'(kif.symbol_count), 32'h5);
        @(negedge clk);
        check("ovf_slots_clear", 32'(slots_w), 32'h0);
        check("ovf_count_clear", 32'(kif.symbol_count), 32'h0);
        check("ovf_done_pulses", 32'(done_pulses - base), 32'h0);
        idle(3);
        press(15);
        wait_event(100, got_done, got_ovf);
        check("after_ovf_done", 32'(got_done), 32'h1);
        check("after_ovf_dash", 32'(kif.morse_one), 32'h2);
        check("after_ovf_count", 32'(kif.symbol_count), 32'h1);
        idle(3);

        // Reset during the third press discards the letter
        press(5); idle(8);
        press(5); idle(8);
        kif.key_in = 1'b1;
        idle(9);
        check("pre_reset_level", 32'(kif.key_level), 32'h1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", 32'(outs_w), 32'h0);
        kif.key_in = 1'b0;
        idle(3);
        reset_n = 1'b1;
        base = done_pulses + ovf_pulses;
        idle(40);
        check("reset_no_strobe", 32'(done_pulses + ovf_pulses - base), 32'h0);
        press(5);
        wait_event(100, got_done, got_ovf);
        check("E_done", 32'(got_done), 32'h1);
        check("E_slots", 32'(slots_w), 32'(10'b01_00_00_00_00));
        check("E_count", 32'(kif.symbol_count), 32'h1);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/morse_key_capture.md
Name: morse_key_capture

Overview:
- Upstream stage of `morse_decoder`. Turns the raw Morse key/button into up to five 2-bit symbol slots plus a `letter_done` strobe.
- Synchronises and debounces the key, then times each press to classify it as dot or dash.
- Times the idle gap after a release to detect the end of a letter.
- Slot encoding matches the decoder: dot = 01, dash = 10, unused = 00.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before `key_level` changes (10 ms at 100 MHz).
- DASH_CYCLES, 25000000, a press lasting this many cycles or more is a dash; anything shorter is a dot.
- LETTER_GAP_CYCLES, 60000000, idle cycles after a release that end the letter.
- CNT_W, 27, width of the debounce, press and gap counters; must hold the largest of the three parameters.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key_in  in  1  raw key, asynchronous to clk, active-high
- key_level  out  1  debounced key level
- morse_one  out  2  slot 1 (01 dot, 10 dash, 00 empty)
- morse_two  out  2  slot 2
- morse_three  out  2  slot 3
- morse_four  out  2  slot 4
- morse_five  out  2  slot 5
- symbol_count  out  3  number of filled slots, 0..5
- letter_done  out  1  one-cycle strobe: slots hold a complete letter
- overflow  out  1  one-cycle strobe: letter had more than 5 symbols and was discarded

Behaviour:
- Reset (async assert, sync deassert): all registered state goes to 0.
  - Outputs: `key_level`=0, all slots=00, `symbol_count`=0, `letter_done`=0, `overflow`=0.
  - Counters: 0. State: IDLE.
- Synchroniser: `key_in` passes through 2 flops before any other logic.
- Debounce:
  - The debounce counter increments while the synchronised key differs from `key_level`.
  - It clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, `key_level` toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach `key_level`.
- FSM states: IDLE, PRESS, GAP, DONE. All transitions are driven by edges of `key_level`.
  - IDLE: rising edge of `key_level` → PRESS, press counter=0.
  - PRESS:
    - The press counter increments each cycle and saturates at DASH_CYCLES.
    - On the falling edge, the symbol is 10 if the counter equals DASH_CYCLES, otherwise 01.
    - Storing: if `symbol_count` < 5, write the symbol to slot [`symbol_count`] and increment `symbol_count`.
    - If `symbol_count` = 5, set the internal `ovf_flag` instead; no slot is written.
    - Go to GAP with gap counter=0.
  - GAP:
    - The gap counter increments each cycle.
    - Rising edge of `key_level` → PRESS; gap counter and press counter clear.
    - Gap counter reaching LETTER_GAP_CYCLES-1 → DONE.
  - DONE (exactly one cycle):
    - If `ovf_flag`=0: `letter_done`=1 while slots and `symbol_count` still hold the letter.
    - If `ovf_flag`=1: `overflow`=1 and `letter_done` stays 0.
    - Next state IDLE. On that transition, all slots clear to 00, `symbol_count` clears to 0, and `ovf_flag` clears.
- The decoder is combinational on `letter_done`, so slot values must be stable and valid for the whole cycle in which `letter_done`=1.
- Boundaries:
  - A rising `key_level` in the DONE cycle is acted on in IDLE the following cycle and is not lost. Debounce latency guarantees the edge is still visible as the level.
  - Press length exactly DASH_CYCLES gives a dash; DASH_CYCLES-1 gives a dot.
  - The 6th and later symbols of a letter are dropped; slots 1..5 keep their values until DONE clears them.
  - `reset_n` asserted mid-press or mid-gap discards the partial letter; no strobe is produced.
  - A key held through reset deassertion is seen as a fresh press after DEBOUNCE_CYCLES.
- Latency:
  - `key_in` to `key_level`: 2 + DEBOUNCE_CYCLES cycles.
  - Release of `key_level` to `letter_done`: LETTER_GAP_CYCLES + 1 cycles.
- `letter_done` and `overflow` are registered and never high in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, DASH_CYCLES=10, LETTER_GAP_CYCLES=20):
- Reset: assert `reset_n`=0 at any time → all outputs 0 asynchronously; they stay 0 for 30 cycles after release with `key_in`=0.
- Letter L (dot, dash, dot, dot), with presses of 5, 15, 5, 5 cycles separated by 8-cycle gaps:
  - After a 20+ cycle gap: exactly one `letter_done` pulse.
  - In that cycle: slots = 01,10,01,01,00 and `symbol_count`=4.
  - Next cycle: all slots 00 and count 0.
- Threshold: a press of 9 cycles at `key_level` stores 01; a press of 10 cycles stores 10. Check each as a separate single-symbol letter → `letter_done` with `morse_one`=01, then 10.
- Bounce: 3-cycle `key_in` pulses repeated with 3-cycle spacing → `key_level` never rises, no symbols, no strobes.
- Overflow: six dots followed by a gap → `overflow` pulses once, `letter_done` never asserts, slots clear afterwards. A following single dash letter decodes normally (`morse_one`=10).
- Reset mid-operation: `reset_n` low during the third press of a letter → no strobe. After release, a new "E" (one dot) gives `letter_done` with slots 01,00,00,00,00.
